// File: rtl/apb_initiator_bridge_if.sv
// Core request/response channel plus the APB initiator port toward the fabric.
interface apb_initiator_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        core_i_psel;
  logic        core_i_penable;
  logic        core_i_pready;
  logic [31:0] core_i_paddr;
  logic        core_i_pwrite;
  logic [31:0] core_i_pwdata;
  logic [3:0]  core_i_pwstrb;
  logic [31:0] core_i_prdata;
  logic        core_i_pslverr;

  // Bridge side: serves the core, initiates APB.
  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb, rsp_ready,
           core_i_pready, core_i_prdata, core_i_pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           core_i_psel, core_i_penable, core_i_paddr, core_i_pwrite,
           core_i_pwdata, core_i_pwstrb
  );

  // Environment side: core issuing requests and APB fabric responding.
  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, rsp_ready,
           core_i_pready, core_i_prdata, core_i_pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           core_i_psel, core_i_penable, core_i_paddr, core_i_pwrite,
           core_i_pwdata, core_i_pwstrb
  );
endinterface

// File: rtl/apb_initiator_bridge.sv
// Valid/ready request channel to APB initiator bridge with misalignment
// rejection and an ACCESS-phase watchdog.
module apb_initiator_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  apb_initiator_bridge_if.master bus
);

  localparam bit              WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WDOG_LAST =
    CNT_W'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e             state_q, state_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic [31:0]        paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic [3:0]         pwstrb_q, pwstrb_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pwstrb_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pwstrb_q    <= pwstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wdog_q      <= wdog_d;
    end
  end

  // Next-state and registered-output logic for the SETUP/ACCESS sequence.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pwstrb_d    = pwstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wdog_d      = wdog_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_addr[1:0] != 2'b00) begin
            // Misaligned: answer with an error, never touch the fabric.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
          end else begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = bus.req_addr;
            pwrite_d  = bus.req_write;
            pwdata_d  = bus.req_wdata;
            pwstrb_d  = bus.req_write ? bus.req_wstrb : 4'b0000;
            state_d   = SETUP;
          end
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        wdog_d    = '0;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (bus.core_i_pready) begin
          // pready wins over a watchdog expiring in the same cycle.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwdata_d    = '0;
          pwstrb_d    = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.core_i_pslverr;
          rsp_rdata_d = (pwrite_q || bus.core_i_pslverr) ? 32'h0 : bus.core_i_prdata;
          state_d     = RESP;
        end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
          // Abandon the hung transfer; a late pready is never sampled.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwdata_d    = '0;
          pwstrb_d    = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.core_i_psel    = psel_q;
  assign bus.core_i_penable = penable_q;
  assign bus.core_i_paddr   = paddr_q;
  assign bus.core_i_pwrite  = pwrite_q;
  assign bus.core_i_pwdata  = pwdata_q;
  assign bus.core_i_pwstrb  = pwstrb_q;

endmodule
